// File: rtl/booth_multiplier_seq.sv
//==============================================================================
// Module   : booth_multiplier_seq
// Function : Sequential radix-2 Booth multiplier, signed N x N -> 2N, one step
//            per clock. Optional abort port when BOOTH_ABORT_EN is defined.
// Revision : 1.0
//==============================================================================
`default_nettype none

module booth_multiplier_seq #(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
`ifdef BOOTH_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             done,
    output logic [2*N-1:0]   Y
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [N:0]       r_m;
    logic [N:0]       r_acc;
    logic [N-1:0]     r_q;
    logic             r_q1;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_y;

    logic             w_abort;
    logic [N:0]       w_sum;
    logic [N:0]       w_acc_sh;
    logic [N-1:0]     w_q_sh;
    logic             w_last;

`ifdef BOOTH_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // One Booth step: conditional add/subtract, then arithmetic shift of {Acc,Q,Q_1}
    always_comb begin
        w_sum = r_acc;
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_acc + r_m;
            2'b10:   w_sum = r_acc - r_m;
            default: w_sum = r_acc;
        endcase
        w_acc_sh = {w_sum[N], w_sum[N:1]};
        w_q_sh   = {w_sum[0], r_q[N-1:1]};
        w_last   = (r_cnt == CW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        ready  = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_abort)     w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m   <= '0;
            r_acc <= '0;
            r_q   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m   <= {A[N-1], A};
                        r_acc <= '0;
                        r_q   <= B;
                        r_q1  <= 1'b0;
                        r_cnt <= CW'(N);
                    end
                end
                S_RUN: begin
                    if (!w_abort) begin
                        r_acc <= w_acc_sh;
                        r_q   <= w_q_sh;
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt - CW'(1);
                        // Result is captured from the post-shift value of the last step
                        if (w_last) r_y <= {w_acc_sh[N-1:0], w_q_sh};
                    end
                end
                default: ;
            endcase
        end
    end

    assign Y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_booth_multiplier_seq.sv
//==============================================================================
// Module   : tb_booth_multiplier_seq
// Function : Self-checking bench for booth_multiplier_seq (vectors + random).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_booth_multiplier_seq;

    localparam int N = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     A;
    logic [N-1:0]     B;
`ifdef BOOTH_ABORT_EN
    logic             abort;
`endif
    logic             ready;
    logic             done;
    logic [2*N-1:0]   Y;

    int n_vec = 0;
    int n_err = 0;

    booth_multiplier_seq #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef BOOTH_ABORT_EN
        .abort (abort),
`endif
        .ready (ready),
        .done  (done),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] y;
    } vec_t;

    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        return p[2*N-1:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 50) begin
            step();
            k++;
        end
        if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    // Full transaction with latency, hold and handshake checks
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [2*N-1:0] exp, input string nm);
        logic [2*N-1:0] y_before;
        bit bad_early, bad_hold;
        wait_ready();
        A = a; B = b; start = 1'b1;
        y_before = Y;
        step();
        start = 1'b0;
        A = N'($urandom); B = N'($urandom);
        bad_early = 0; bad_hold = 0;
        for (int k = 0; k < N; k++) begin
            if (done !== 1'b0 || ready !== 1'b0) bad_early = 1;
            if (Y !== y_before) bad_hold = 1;
            step();
        end
        chk({nm, "_run_quiet"}, {31'd0, bad_early | bad_hold}, 32'd0);
        chk({nm, "_done"},      {30'd0, done, ready}, 32'd2);
        chk({nm, "_Y"},         {16'd0, Y}, {16'd0, exp});
        step();
        chk({nm, "_after"},     {14'd0, done, ready, Y}, {14'd0, 1'b0, 1'b1, exp});
    endtask

    vec_t vecs[10];

    initial begin
        int t_done[$];
        logic [2*N-1:0] y_seen[$];
        logic [N-1:0] ra, rb;
        bit bad;

        vecs[0] = '{8'h03, 8'hFC, 16'hFFF4};
        vecs[1] = '{8'h80, 8'h80, 16'h4000};
        vecs[2] = '{8'h7F, 8'hFF, 16'hFF81};
        vecs[3] = '{8'h00, 8'hB3, 16'h0000};
        vecs[4] = '{8'h05, 8'h06, 16'h001E};
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
        vecs[6] = '{8'h80, 8'h7F, 16'hC080};
        vecs[7] = '{8'h7F, 8'h7F, 16'h3F01};
        vecs[8] = '{8'h80, 8'h01, 16'hFF80};
        vecs[9] = '{8'h07, 8'h09, 16'h003F};

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
`ifdef BOOTH_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) step();
        chk("reset_state", {14'd0, done, ready, Y}, {14'd0, 1'b0, 1'b1, 16'h0000});
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].y, $sformatf("vec%0d", i));

        for (int i = 0; i < 20; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            run_op(ra, rb, ref_mul(ra, rb), $sformatf("rnd%0d", i));
        end

        // Back-to-back with start held; operands scrambled while busy
        wait_ready();
        start = 1'b1; A = 8'd5; B = 8'd6;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done === 1'b1) begin
                t_done.push_back(c);
                y_seen.push_back(Y);
            end
            if (ready === 1'b0 && done === 1'b0) begin
                A = N'($urandom); B = N'($urandom);
            end else begin
                A = 8'd5; B = 8'd6;
            end
        end
        start = 1'b0;
        chk("b2b_count", t_done.size(), 32'd4);
        bad = 0;
        for (int i = 0; i < t_done.size(); i++) begin
            if (y_seen[i] !== 16'h001E) bad = 1;
            if (i > 0 && (t_done[i] - t_done[i-1]) != N + 2) bad = 1;
        end
        chk("b2b_spacing_Y", {31'd0, bad}, 32'd0);

        // Asynchronous reset in the middle of a run
        wait_ready();
        A = 8'd7; B = 8'd9; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset", {14'd0, done, ready, Y}, {14'd0, 1'b0, 1'b1, 16'h0000});
        #2 rst = 1'b0;
        bad = 0;
        for (int c = 0; c < N + 3; c++) begin
            step();
            if (done !== 1'b0) bad = 1;
        end
        chk("midrun_no_done", {31'd0, bad}, 32'd0);
        run_op(8'd7, 8'd9, 16'h003F, "post_reset");

`ifdef BOOTH_ABORT_EN
        wait_ready();
        A = 8'd2; B = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {14'd0, done, ready, Y}, {14'd0, 1'b0, 1'b1, 16'h003F});
        bad = 0;
        for (int c = 0; c < N + 3; c++) begin
            step();
            if (done !== 1'b0 || Y !== 16'h003F) bad = 1;
        end
        chk("abort_no_done", {31'd0, bad}, 32'd0);
        run_op(8'd2, 8'd2, 16'h0004, "post_abort");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
Sequential radix-2 Booth multiplier for signed two's-complement operands, one Booth step per clock. Its add/subtract/shift datapath is the stage that feeds the Booth partial-product gate cells; the control FSM sequences operand load, N iterations and result delivery. Start/done handshake toward the surrounding test or ALU logic.

Parameters:
N, 8, operand width in bits (N >= 2); product width is 2N.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when ready=1
A  input  N  multiplicand, signed; sampled with start
B  input  N  multiplier, signed; sampled with start
ready  output  1  high in IDLE; block accepts start
done  output  1  one-cycle pulse; Y valid and updated
Y  output  2N  signed product; holds until the next completion

Behaviour:
- Reset (asynchronous, any state): state=IDLE, ready=1, done=0, Y=0, internal Acc/Q/Q_1/count=0.
- Internal registers: M (N+1 bits, sign-extended A), Acc (N+1 bits), Q (N bits), Q_1 (1 bit), count (clog2(N+1) bits).
- FSM states: IDLE, RUN, DONE.
- IDLE: ready=1. On an edge with start=1, load M={A[N-1],A}, Acc=0, Q=B, Q_1=0, count=N, and go to RUN. With start=0, stay.
- RUN: ready=0. Each edge runs one Booth step:
  - {Q[0],Q_1}=01: Acc+M
  - 10: Acc-M
  - 00 or 11: no change
  - Then arithmetic right shift of {Acc,Q,Q_1} by 1, replicating Acc MSB.
  - Decrement count.
- RUN exit: on the edge where count goes 1->0, go to DONE and load Y={Acc,Q} after the final step, taking the low 2N bits.
- DONE: done=1 and ready=0 for exactly one cycle. Next edge goes to IDLE.
- Latency: start sampled at edge 0, Y valid and done=1 after edge N, ready=1 again after edge N+1. Throughput is one product per N+2 cycles.
- start is ignored in RUN and DONE. Holding start high gives back-to-back operations, each accepted in IDLE.
- A and B may change freely after the accept edge. They are not used again.
- Acc is N+1 bits so that -M for A=-2^(N-1) does not overflow. The 2N-bit result is exact for all operand pairs, including (-2^(N-1))*(-2^(N-1)).
- Y and done change only on the DONE transition. Y is never partially updated.
- Reset mid-RUN: immediate return to IDLE with the values above. Y is cleared and no done pulse is produced.

Optional Feature:
BOOTH_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 at an edge in RUN returns to IDLE.
  - No done pulse; Y keeps its previous value.
  - abort is ignored in IDLE and DONE, and has priority over the RUN step.
- Undefined: no abort port. RUN always completes N steps.

Test Plan:
- Reset, then N=8, A=3, B=-4, start pulse -> done pulses 8 cycles after the accept edge, Y=16'hFFF4, ready back 1 cycle later.
- A=-128, B=-128 -> Y=16'h4000. A=127, B=-1 -> Y=16'hFF81. A=0, B=-77 -> Y=16'h0000.
- start held high with A=5, B=6 -> consecutive done pulses spaced 10 cycles apart, Y=16'h001E each time. Operand change during RUN has no effect.
- Assert rst at cycle 4 of RUN (A=7, B=9) -> ready=1, done=0, Y=0 immediately. A following start with the same operands gives Y=16'h003F.
- With BOOTH_ABORT_EN: after a completed product Y=16'h003F, start A=2, B=2, abort in cycle 3 of RUN -> IDLE next cycle, no done pulse, Y stays 16'h003F.
